uart_tx_fifo: RTL

Parametrised UART transmitter with an input FIFO, runtime baud divisor, and runtime frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. It sits between the host-side byte producer and the serial pin. It replaces fixed-rate, single-byte transmission with buffered back-to-back framing.

---
 rtl/uart_tx_fifo.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered UART transmitter: an 8-bit FIFO feeds a framing engine with a
// runtime baud divisor and runtime frame format (5-8 data bits, none/even/odd
// parity, 1 or 2 stop bits). Frames go out back to back while the FIFO holds
// data.
//
// Ports:
//   i_Clock       system clock
//   i_Reset       asynchronous active-high reset
//   i_Tx_DV       write strobe, pushes i_Tx_Byte into the FIFO
//   i_Tx_Byte     byte to send, LSB first
//   i_Baud_Div    clocks per bit (0 and 1 behave as 2)
//   i_Data_Bits   data length code: 0..3 -> 5..8 bits
//   i_Parity      00 none, 01 even, 10 odd, 11 none
//   i_Stop2       0 one stop bit, 1 two stop bits
//   o_Tx_Serial   serial line, idles high
//   o_Tx_Active   high while a frame is on the line
//   o_Tx_Done     pulse in the last cycle of each frame
//   o_Tx_Ready    FIFO not full
//   o_Fifo_Count  FIFO occupancy
//   o_Overflow    pulse when a write is dropped on a full FIFO
module uart_tx_fifo #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [7:0]           i_Tx_Byte,
  input  logic [DIV_WIDTH-1:0] i_Baud_Div,
  input  logic [1:0]           i_Data_Bits,
  input  logic [1:0]           i_Parity,
  input  logic                 i_Stop2,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Ready,
  output logic [FIFO_AW:0]     o_Fifo_Count,
  output logic                 o_Overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_n;
  logic               r_ready;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [7:0]         w_head;

  // Framing engine state
  state_t               r_state;
  state_t               w_state_n;
  logic [DIV_WIDTH-1:0] r_clk_cnt;
  logic [DIV_WIDTH-1:0] w_clk_cnt_n;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_n;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_n;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] w_div_n;
  logic [2:0]           r_last_idx;
  logic [2:0]           w_last_idx_n;
  logic                 r_par_en;
  logic                 w_par_en_n;
  logic                 r_par_bit;
  logic                 w_par_bit_n;
  logic                 r_stop2;
  logic                 w_stop2_n;
  logic                 w_bit_end;

  // Line-side values of the current state, registered onto the outputs
  logic w_serial;
  logic w_active;
  logic w_done;
  logic r_serial;
  logic r_active;
  logic r_done;

  // Config captured at pop time
  logic [DIV_WIDTH-1:0] w_div_clamp;
  logic [7:0]           w_data_mask;
  logic                 w_data_xor;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle
  assign w_push  = i_Tx_DV & ~w_full;
  assign w_drop  = i_Tx_DV & w_full;
  assign w_head  = r_mem[r_rd_ptr];

  assign w_div_clamp = (i_Baud_Div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_Baud_Div;
  assign w_data_mask = 8'hFF >> (2'd3 - i_Data_Bits);
  assign w_data_xor  = ^(w_head & w_data_mask);

  assign w_bit_end = (r_clk_cnt == (r_div - DIV_WIDTH'(1)));

  // Occupancy after this cycle's push/pop
  always_comb begin
    w_count_n = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_n = r_count + CW'(1);
      2'b01:   w_count_n = r_count - CW'(1);
      default: w_count_n = r_count;
    endcase
  end

  // FIFO storage (no reset needed: contents are only read when counted valid)
  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Tx_Byte;
    end
  end

  // FIFO pointers, count and status flags
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_count    <= w_count_n;
      r_ready    <= (w_count_n != CW'(DEPTH));
      r_overflow <= w_drop;
    end
  end

  // Framing FSM: state and datapath registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_div      <= '0;
      r_last_idx <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_clk_cnt  <= w_clk_cnt_n;
      r_bit_idx  <= w_bit_idx_n;
      r_shift    <= w_shift_n;
      r_div      <= w_div_n;
      r_last_idx <= w_last_idx_n;
      r_par_en   <= w_par_en_n;
      r_par_bit  <= w_par_bit_n;
      r_stop2    <= w_stop2_n;
    end
  end

  // Framing FSM: next state, pop request and line value
  always_comb begin
    w_state_n    = r_state;
    w_clk_cnt_n  = r_clk_cnt;
    w_bit_idx_n  = r_bit_idx;
    w_shift_n    = r_shift;
    w_div_n      = r_div;
    w_last_idx_n = r_last_idx;
    w_par_en_n   = r_par_en;
    w_par_bit_n  = r_par_bit;
    w_stop2_n    = r_stop2;
    w_pop        = 1'b0;
    w_serial     = 1'b1;
    w_active     = 1'b1;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_active = 1'b0;
        w_pop    = ~w_empty;
      end

      S_START: begin
        w_serial = 1'b0;
        if (w_bit_end) begin
          w_clk_cnt_n = '0;
          w_bit_idx_n = '0;
          w_state_n   = S_DATA;
        end else begin
          w_clk_cnt_n = r_clk_cnt + DIV_WIDTH'(1);
        end
      end

      S_DATA: begin
        w_serial = r_shift[0];
        if (w_bit_end) begin
          w_clk_cnt_n = '0;
          w_shift_n   = {1'b0, r_shift[7:1]};
          if (r_bit_idx == r_last_idx) begin
            w_bit_idx_n = '0;
            w_state_n   = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_n = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_n = r_clk_cnt + DIV_WIDTH'(1);
        end
      end

      S_PARITY: begin
        w_serial = r_par_bit;
        if (w_bit_end) begin
          w_clk_cnt_n = '0;
          w_bit_idx_n = '0;
          w_state_n   = S_STOP;
        end else begin
          w_clk_cnt_n = r_clk_cnt + DIV_WIDTH'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_clk_cnt_n = '0;
          // r_bit_idx counts stop bits already completed
          if (r_bit_idx == {2'b00, r_stop2}) begin
            w_done      = 1'b1;
            w_bit_idx_n = '0;
            w_pop       = ~w_empty;
            w_state_n   = S_IDLE;
          end else begin
            w_bit_idx_n = r_bit_idx + 3'd1;
          end
        end else begin
          w_clk_cnt_n = r_clk_cnt + DIV_WIDTH'(1);
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Popping loads the next frame and freezes its format until it ends
    if (w_pop) begin
      w_state_n    = S_START;
      w_clk_cnt_n  = '0;
      w_bit_idx_n  = '0;
      w_shift_n    = w_head;
      w_div_n      = w_div_clamp;
      w_last_idx_n = 3'd4 + {1'b0, i_Data_Bits};
      w_par_en_n   = ^i_Parity;
      w_par_bit_n  = i_Parity[1] ? ~w_data_xor : w_data_xor;
      w_stop2_n    = i_Stop2;
    end
  end

  // Registered line outputs, one cycle behind the FSM state
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_serial <= w_serial;
      r_active <= w_active;
      r_done   <= w_done;
    end
  end

  assign o_Tx_Serial  = r_serial;
  assign o_Tx_Active  = r_active;
  assign o_Tx_Done    = r_done;
  assign o_Tx_Ready   = r_ready;
  assign o_Fifo_Count = r_count;
  assign o_Overflow   = r_overflow;

endmodule
